// File: rtl/gray_seq_gen_if.sv
// Output bus of gray_seq_gen: Gray word, binary mirror, valid/ready handshake and status flags.
interface gray_seq_gen_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] b;
    logic             g_valid;
    logic             g_ready;
    logic             tc;
    logic             err;

    modport master (
        output g,
        output b,
        output g_valid,
        output tc,
        output err,
        input  g_ready
    );

    modport slave (
        input  g,
        input  b,
        input  g_valid,
        input  tc,
        input  err,
        output g_ready
    );
endinterface

// File: rtl/gray_seq_gen.sv
// Registered Gray-code up/down sequence generator with valid/ready output and binary mirror.
// Optional sticky one-bit-change checker on accepted step words: define GRAY_STEP_CHK_EN.
module gray_seq_gen #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SAT   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              up_dn,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    gray_seq_gen_if.master    bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] b_nxt;
    logic [WIDTH-1:0] g_q;
    logic             accept_c;
    logic             step_c;
    logic             tc_c;
    logic             new_word_c;

    assign tc_c     = up_dn ? (&b_q) : ~(|b_q);
    assign accept_c = (state == FULL) && bus.g_ready;
    assign step_c   = en && !load && ((state == EMPTY) || bus.g_ready);

    // State register; g is re-encoded from the next binary value so g and b move together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            b_q   <= '0;
            g_q   <= '0;
        end else begin
            state <= state_nxt;
            b_q   <= b_nxt;
            g_q   <= b_nxt ^ (b_nxt >> 1);
        end
    end

    // Next-state: load beats step, step beats accept-only; SAT terminal step produces no word.
    always_comb begin
        state_nxt  = state;
        b_nxt      = b_q;
        new_word_c = 1'b0;
        if (load) begin
            b_nxt     = load_val;
            state_nxt = FULL;
        end else if (step_c) begin
            if (tc_c && (SAT != 0)) begin
                if (accept_c) begin
                    state_nxt = EMPTY;
                end
            end else begin
                b_nxt      = up_dn ? (b_q + WIDTH'(1)) : (b_q - WIDTH'(1));
                state_nxt  = FULL;
                new_word_c = 1'b1;
            end
        end else if (accept_c) begin
            state_nxt = EMPTY;
        end
    end

    assign bus.g       = g_q;
    assign bus.b       = b_q;
    assign bus.g_valid = (state == FULL);
    assign bus.tc      = tc_c;

`ifdef GRAY_STEP_CHK_EN
    logic [WIDTH-1:0] last_g;
    logic             last_vld;
    logic             word_from_load;
    logic             err_q;

    // Compare each accepted step word against the previously accepted word.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_g         <= '0;
            last_vld       <= 1'b0;
            word_from_load <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            if (load) begin
                word_from_load <= 1'b1;
            end else if (new_word_c) begin
                word_from_load <= 1'b0;
            end
            if (accept_c) begin
                if (last_vld && !word_from_load && ($countones(g_q ^ last_g) != 1)) begin
                    err_q <= 1'b1;
                end
                last_g   <= g_q;
                last_vld <= 1'b1;
            end
        end
    end

    assign bus.err = err_q;
`else
    logic unused_new_word;
    assign unused_new_word = new_word_c;
    assign bus.err         = 1'b0;
`endif

endmodule
